// File: rtl/dma_address_count_bank.sv
// Address/word-count register bank for a parametrised KF8237-style DMA controller.
// State updates on the falling clock edge; reset is asynchronous and active-high.
module dma_address_count_bank #(
   parameter int CHANNELS  = 4,
   parameter int REG_WIDTH = 16
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [7:0]           internal_data_bus_i,
   output logic [7:0]           read_data_o,
   input  logic [CHANNELS-1:0]  write_address_i,
   input  logic [CHANNELS-1:0]  write_count_i,
   input  logic [CHANNELS-1:0]  read_address_i,
   input  logic [CHANNELS-1:0]  read_count_i,
   input  logic                 clear_byte_pointer_i,
   input  logic                 master_clear_i,
   input  logic [CHANNELS-1:0]  channel_select_i,
   input  logic                 initialize_current_i,
   input  logic                 next_word_i,
   input  logic [CHANNELS-1:0]  address_hold_i,
   input  logic [CHANNELS-1:0]  address_decrement_i,
   input  logic [CHANNELS-1:0]  autoinitialize_i,
   output logic                 underflow_o,
   output logic                 update_high_address_o,
   output logic [REG_WIDTH-1:0] transfer_address_o,
   output logic [CHANNELS-1:0]  terminal_count_o
);

   localparam int LANES = REG_WIDTH / 8;
   localparam int IDX_W = $clog2(LANES);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [REG_WIDTH-1:0]  base_addr_q [CHANNELS];
   logic [REG_WIDTH-1:0]  base_addr_d [CHANNELS];
   logic [REG_WIDTH-1:0]  base_cnt_q  [CHANNELS];
   logic [REG_WIDTH-1:0]  base_cnt_d  [CHANNELS];
   logic [REG_WIDTH-1:0]  cur_addr_q  [CHANNELS];
   logic [REG_WIDTH-1:0]  cur_addr_d  [CHANNELS];
   logic [REG_WIDTH-1:0]  cur_cnt_q   [CHANNELS];
   logic [REG_WIDTH-1:0]  cur_cnt_d   [CHANNELS];
   logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
   logic [2*CHANNELS-1:0] rd_prev_q, rd_now;
   logic [REG_WIDTH-1:0]  xfer_addr_q, xfer_addr_d;
   logic [CHANNELS-1:0]   tc_q, tc_d;

   logic [SEL_W-1:0]      sel;
   logic [REG_WIDTH-1:0]  sel_addr, sel_cnt, step_addr, rd_reg;
   logic                  tc_event, wr_any, rd_end;
   logic [7:0]            rd_byte;

   assign rd_now = {read_count_i, read_address_i};

   always_comb begin
      sel = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (channel_select_i[c]) sel = SEL_W'(c);
      end
   end

   assign sel_addr = cur_addr_q[sel];
   assign sel_cnt  = cur_cnt_q[sel];
   assign tc_event = next_word_i && (sel_cnt == '0);

   always_comb begin
      step_addr = sel_addr;
      if (!address_hold_i[sel]) begin
         if (address_decrement_i[sel]) step_addr = sel_addr - REG_WIDTH'(1);
         else                          step_addr = sel_addr + REG_WIDTH'(1);
      end
   end

   assign underflow_o           = tc_event;
   assign update_high_address_o = next_word_i &&
                                  (step_addr[REG_WIDTH-1:8] != xfer_addr_q[REG_WIDTH-1:8]);

   // Reverse scan so the lowest-index address strobe ends up with the last word.
   always_comb begin
      rd_reg = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (read_count_i[c]) rd_reg = cur_cnt_q[c];
      end
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (read_address_i[c]) rd_reg = cur_addr_q[c];
      end
      rd_byte = '0;
      for (int k = 0; k < LANES; k++) begin
         if (byte_idx_q == IDX_W'(k)) rd_byte = rd_reg[8*k +: 8];
      end
   end

   assign read_data_o        = rd_byte;
   assign transfer_address_o = xfer_addr_q;
   assign terminal_count_o   = tc_q;

   assign wr_any = (|write_address_i) || (|write_count_i);
   assign rd_end = (|rd_prev_q) && (rd_prev_q != rd_now);

   always_comb begin
      byte_idx_d = byte_idx_q;
      if (wr_any || rd_end) begin
         byte_idx_d = (byte_idx_q == IDX_W'(LANES - 1)) ? '0 : byte_idx_q + IDX_W'(1);
      end
      if (clear_byte_pointer_i || master_clear_i) byte_idx_d = '0;
   end

   always_comb begin
      base_addr_d = base_addr_q;
      base_cnt_d  = base_cnt_q;
      cur_addr_d  = cur_addr_q;
      cur_cnt_d   = cur_cnt_q;
      tc_d        = '0;
      xfer_addr_d = sel_addr;
      for (int c = 0; c < CHANNELS; c++) begin
         if (write_address_i[c] || write_count_i[c]) begin
            for (int k = 0; k < LANES; k++) begin
               if (byte_idx_q == IDX_W'(k)) begin
                  if (write_address_i[c]) begin
                     base_addr_d[c][8*k +: 8] = internal_data_bus_i;
                     cur_addr_d[c][8*k +: 8]  = internal_data_bus_i;
                  end
                  if (write_count_i[c]) begin
                     base_cnt_d[c][8*k +: 8] = internal_data_bus_i;
                     cur_cnt_d[c][8*k +: 8]  = internal_data_bus_i;
                  end
               end
            end
         end else if ((sel == SEL_W'(c)) && initialize_current_i) begin
            cur_addr_d[c] = base_addr_q[c];
            cur_cnt_d[c]  = base_cnt_q[c];
         end else if ((sel == SEL_W'(c)) && next_word_i) begin
            cur_addr_d[c] = step_addr;
            cur_cnt_d[c]  = sel_cnt - REG_WIDTH'(1);
            if (tc_event) begin
               tc_d[c] = 1'b1;
               if (autoinitialize_i[c]) begin
                  cur_addr_d[c] = base_addr_q[c];
                  cur_cnt_d[c]  = base_cnt_q[c];
               end
            end
         end
      end
      if (master_clear_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            base_addr_d[c] = '0;
            base_cnt_d[c]  = '0;
            cur_addr_d[c]  = '0;
            cur_cnt_d[c]   = '0;
         end
         tc_d        = '0;
         xfer_addr_d = '0;
      end
   end

   always_ff @(negedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            base_addr_q[c] <= '0;
            base_cnt_q[c]  <= '0;
            cur_addr_q[c]  <= '0;
            cur_cnt_q[c]   <= '0;
         end
         byte_idx_q  <= '0;
         rd_prev_q   <= '0;
         xfer_addr_q <= '0;
         tc_q        <= '0;
      end else begin
         base_addr_q <= base_addr_d;
         base_cnt_q  <= base_cnt_d;
         cur_addr_q  <= cur_addr_d;
         cur_cnt_q   <= cur_cnt_d;
         byte_idx_q  <= byte_idx_d;
         rd_prev_q   <= rd_now;
         xfer_addr_q <= xfer_addr_d;
         tc_q        <= tc_d;
      end
   end

endmodule

// File: tb/tb_dma_address_count_bank.sv
// Directed bench for dma_address_count_bank at 4 channels x 24 bits (3 byte lanes).
module tb_dma_address_count_bank;

   localparam int CH    = 4;
   localparam int RW    = 24;
   localparam int LANES = RW / 8;

   logic          clock = 1'b1;
   logic          reset = 1'b0;
   logic [7:0]    internal_data_bus = '0;
   logic [7:0]    read_data;
   logic [CH-1:0] write_address = '0, write_count = '0;
   logic [CH-1:0] read_address = '0, read_count = '0;
   logic          clear_byte_pointer = 1'b0, master_clear = 1'b0;
   logic [CH-1:0] channel_select = '0;
   logic          initialize_current = 1'b0, next_word = 1'b0;
   logic [CH-1:0] address_hold = '0, address_decrement = '0, autoinitialize = '0;
   logic          underflow, update_high_address;
   logic [RW-1:0] transfer_address;
   logic [CH-1:0] terminal_count;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int            ch;
      bit            is_cnt;
      logic [RW-1:0] value;
   } vec_t;
   vec_t vecs [8];

   dma_address_count_bank #(.CHANNELS(CH), .REG_WIDTH(RW)) dut (
      .clock_i               (clock),
      .reset_i               (reset),
      .internal_data_bus_i   (internal_data_bus),
      .read_data_o           (read_data),
      .write_address_i       (write_address),
      .write_count_i         (write_count),
      .read_address_i        (read_address),
      .read_count_i          (read_count),
      .clear_byte_pointer_i  (clear_byte_pointer),
      .master_clear_i        (master_clear),
      .channel_select_i      (channel_select),
      .initialize_current_i  (initialize_current),
      .next_word_i           (next_word),
      .address_hold_i        (address_hold),
      .address_decrement_i   (address_decrement),
      .autoinitialize_i      (autoinitialize),
      .underflow_o           (underflow),
      .update_high_address_o (update_high_address),
      .transfer_address_o    (transfer_address),
      .terminal_count_o      (terminal_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_reg(int ch, bit is_cnt, logic [RW-1:0] val);
      for (int k = 0; k < LANES; k++) begin
         internal_data_bus = val[8*k +: 8];
         if (is_cnt) write_count[ch] = 1'b1;
         else        write_address[ch] = 1'b1;
         step();
         write_count   = '0;
         write_address = '0;
      end
      internal_data_bus = '0;
   endtask

   task automatic read_reg(int ch, bit is_cnt, output logic [RW-1:0] val);
      val = '0;
      for (int k = 0; k < LANES; k++) begin
         if (is_cnt) read_count[ch] = 1'b1;
         else        read_address[ch] = 1'b1;
         #1;
         val[8*k +: 8] = read_data;
         step();
         read_count   = '0;
         read_address = '0;
         step();
      end
   endtask

   initial begin
      logic [RW-1:0] v;

      vecs[0] = '{0, 1'b0, 24'h123456};
      vecs[1] = '{0, 1'b1, 24'hFEDCBA};
      vecs[2] = '{1, 1'b0, 24'h000001};
      vecs[3] = '{1, 1'b1, 24'hFFFFFF};
      vecs[4] = '{2, 1'b0, 24'hA5A55A};
      vecs[5] = '{3, 1'b1, 24'h000000};
      vecs[6] = '{3, 1'b0, 24'h800001};
      vecs[7] = '{2, 1'b1, 24'h010203};

      #2 reset = 1'b1;
      #1;
      check("rst_read_data", 32'(read_data), 32'h0);
      check("rst_xfer_addr", 32'(transfer_address), 32'h0);
      check("rst_tc", 32'(terminal_count), 32'h0);
      check("rst_underflow", 32'(underflow), 32'h0);
      check("rst_uha", 32'(update_high_address), 32'h0);
      step();
      reset = 1'b0;

      // byte pointer wraps across three lanes
      write_reg(1, 1'b0, 24'h563412);
      read_reg(1, 1'b0, v);
      check("wrap_read1", 32'(v), 32'h563412);
      read_reg(1, 1'b0, v);
      check("wrap_read2", 32'(v), 32'h563412);
      channel_select = 4'b0010;
      step();
      check("wrap_xfer", 32'(transfer_address), 32'h563412);

      for (int i = 0; i < 8; i++) write_reg(vecs[i].ch, vecs[i].is_cnt, vecs[i].value);
      for (int i = 0; i < 8; i++) begin
         read_reg(vecs[i].ch, vecs[i].is_cnt, v);
         check($sformatf("table_%0d", i), 32'(v), 32'(vecs[i].value));
      end

      // read priority: address strobes beat count strobes, lowest index wins
      read_address[2] = 1'b1;
      read_count[0]   = 1'b1;
      #1 check("rd_prio_addr", 32'(read_data), 32'h5A);
      step();
      read_address = '0;
      read_count   = '0;
      step();
      read_count = 4'b1010;
      #1 check("rd_prio_cnt_byte1", 32'(read_data), 32'hFF);
      step();
      read_count = '0;
      step();
      clear_byte_pointer = 1'b1;
      step();
      clear_byte_pointer = 1'b0;

      channel_select = 4'b0000;
      step();
      check("sel_none_ch0", 32'(transfer_address), 32'h123456);
      channel_select = 4'b1010;
      step();
      check("sel_multi_lowest", 32'(transfer_address), 32'h000001);

      // increment with carry into the high byte, then TC
      write_reg(2, 1'b0, 24'h0000FF);
      write_reg(2, 1'b1, 24'h000001);
      channel_select = 4'b0100;
      step();
      check("inc_xfer0", 32'(transfer_address), 32'h0000FF);
      next_word = 1'b1;
      #1;
      check("inc_uha", 32'(update_high_address), 32'h1);
      check("inc_no_underflow", 32'(underflow), 32'h0);
      step();
      check("inc_underflow2", 32'(underflow), 32'h1);
      check("inc_tc_early", 32'(terminal_count), 32'h0);
      step();
      check("inc_tc", 32'(terminal_count), 32'b0100);
      check("inc_xfer_0100", 32'(transfer_address), 32'h000100);
      next_word = 1'b0;
      step();
      check("inc_tc_clear", 32'(terminal_count), 32'h0);
      check("inc_xfer_lag", 32'(transfer_address), 32'h000101);
      read_reg(2, 1'b1, v);
      check("inc_count_wrap", 32'(v), 32'hFFFFFF);

      // autoinitialize with decrement, count 0
      autoinitialize[0]    = 1'b1;
      address_decrement[0] = 1'b1;
      write_reg(0, 1'b0, 24'h001000);
      write_reg(0, 1'b1, 24'h000000);
      channel_select = 4'b0001;
      next_word = 1'b1;
      #1 check("ai_underflow", 32'(underflow), 32'h1);
      step();
      check("ai_tc", 32'(terminal_count), 32'b0001);
      next_word = 1'b0;
      step();
      check("ai_tc_clear", 32'(terminal_count), 32'h0);
      read_reg(0, 1'b0, v);
      check("ai_addr", 32'(v), 32'h001000);
      read_reg(0, 1'b1, v);
      check("ai_count", 32'(v), 32'h000000);

      // hold mode overrides decrement
      address_hold[3]      = 1'b1;
      address_decrement[3] = 1'b1;
      write_reg(3, 1'b0, 24'h00ABCD);
      write_reg(3, 1'b1, 24'h000002);
      channel_select = 4'b1000;
      next_word = 1'b1;
      step();
      check("hold_tc1", 32'(terminal_count), 32'h0);
      step();
      check("hold_tc2", 32'(terminal_count), 32'h0);
      step();
      check("hold_tc3", 32'(terminal_count), 32'b1000);
      next_word = 1'b0;
      step();
      read_reg(3, 1'b0, v);
      check("hold_addr", 32'(v), 32'h00ABCD);
      read_reg(3, 1'b1, v);
      check("hold_count", 32'(v), 32'hFFFFFF);

      // write strobe beats a simultaneous next_word on the same channel
      next_word = 1'b1;
      write_reg(3, 1'b1, 24'h000000);
      check("coll_tc", 32'(terminal_count), 32'h0);
      next_word = 1'b0;
      step();
      read_reg(3, 1'b1, v);
      check("coll_count", 32'(v), 32'h000000);
      read_reg(3, 1'b0, v);
      check("coll_addr", 32'(v), 32'h00ABCD);

      // back-to-back TCs on different channels
      write_reg(1, 1'b1, 24'h000000);
      write_reg(2, 1'b1, 24'h000000);
      channel_select = 4'b0010;
      next_word = 1'b1;
      step();
      check("b2b_tc_ch1", 32'(terminal_count), 32'b0010);
      channel_select = 4'b0100;
      step();
      check("b2b_tc_ch2", 32'(terminal_count), 32'b0100);
      next_word = 1'b0;
      step();
      check("b2b_tc_clear", 32'(terminal_count), 32'h0);

      // master clear after a single byte write
      write_address[0]  = 1'b1;
      internal_data_bus = 8'h77;
      step();
      write_address     = '0;
      master_clear      = 1'b1;
      step();
      master_clear = 1'b0;
      check("mc_xfer", 32'(transfer_address), 32'h0);
      check("mc_tc", 32'(terminal_count), 32'h0);
      write_count[1]    = 1'b1;
      internal_data_bus = 8'hAB;
      step();
      write_count        = '0;
      internal_data_bus  = '0;
      clear_byte_pointer = 1'b1;
      step();
      clear_byte_pointer = 1'b0;
      read_reg(1, 1'b1, v);
      check("mc_byte0", 32'(v), 32'h0000AB);
      read_reg(0, 1'b0, v);
      check("mc_addr0", 32'(v), 32'h0);
      read_reg(3, 1'b0, v);
      check("mc_addr3", 32'(v), 32'h0);

      // asynchronous reset between clock edges
      write_reg(2, 1'b0, 24'h000345);
      write_reg(2, 1'b1, 24'h000000);
      channel_select = 4'b0100;
      step();
      next_word = 1'b1;
      step();
      check("ar_pre_tc", 32'(terminal_count), 32'b0100);
      check("ar_pre_xfer", 32'(transfer_address), 32'h000345);
      #2;
      reset           = 1'b1;
      next_word       = 1'b0;
      read_address[2] = 1'b1;
      #1;
      check("ar_xfer", 32'(transfer_address), 32'h0);
      check("ar_tc", 32'(terminal_count), 32'h0);
      check("ar_read_data", 32'(read_data), 32'h0);
      check("ar_underflow", 32'(underflow), 32'h0);
      check("ar_uha", 32'(update_high_address), 32'h0);
      read_address = '0;
      step();
      reset = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
